// File: rtl/conv_window_reader.sv
// conv_window_reader: four rotating line stores feeding a 3x3 window
// generator. The ingress stream fills the stores in raster order. Once three
// full lines are buffered, the read side walks the top line column by column
// and emits one window per accepted cycle. Windows wrap around at the column
// edges. When a line has been consumed, its slot is handed back to the writer
// and line_done pulses for one cycle.
module conv_window_reader #(
  parameter int DATA_WIDTH            = 8,
  parameter int IMAGE_WIDTH_SIZE      = 512,
  parameter int IMAGE_WIDTH_LOG2_SIZE = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [9*DATA_WIDTH-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    line_done
);

  localparam int W  = IMAGE_WIDTH_SIZE;
  localparam int CB = IMAGE_WIDTH_LOG2_SIZE;
  localparam int CW = IMAGE_WIDTH_LOG2_SIZE + 3;

  localparam logic [CW-1:0] LINE_PIX = CW'(W);
  localparam logic [CW-1:0] FULL_PIX = CW'(4 * W);
  localparam logic [CW-1:0] WIN_PIX  = CW'(3 * W);
  localparam logic [CB-1:0] LAST_COL = CB'(W - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] READ = 1'b1;

  // Line stores. These are deliberately left unreset, since only the
  // pointers decide what is valid.
  logic [DATA_WIDTH-1:0] mem [0:3][0:W-1];

  logic [1:0]    wsel, rsel;
  logic [CB-1:0] wcol, rcol;
  logic [CW-1:0] count, count_next;
  logic [0:0]    state;

  logic wr_en, rd_acc, rd_last;

  assign s_ready = (count < FULL_PIX);
  assign m_valid = (state == READ);
  assign wr_en   = s_valid && s_ready;
  assign rd_acc  = m_valid && m_ready;
  assign rd_last = rd_acc && (rcol == LAST_COL);

  // Store accepted pixels into the current write slot.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wsel][wcol] <= s_data;
  end

  // Advance the write pointer, moving to the next slot at the end of each line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wsel <= '0;
      wcol <= '0;
    end else if (wr_en) begin
      if (wcol == LAST_COL) begin
        wcol <= '0;
        wsel <= wsel + 2'd1;
      end else begin
        wcol <= wcol + CB'(1);
      end
    end
  end

  // Compute the fill level: +1 per pixel written, -W when a top line is released.
  always_comb begin
    count_next = count;
    if (wr_en)   count_next = count_next + CW'(1);
    if (rd_last) count_next = count_next - LINE_PIX;
  end

  // Register the fill level.
  always_ff @(posedge clk) begin
    if (!rst_n) count <= '0;
    else        count <= count_next;
  end

  // Read FSM. A line starts only when three full lines are present, judged on
  // the registered count, so m_valid drops for at least one cycle between lines.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rsel  <= '0;
      rcol  <= '0;
    end else begin
      case (state)
        IDLE: if (count >= WIN_PIX) state <= READ;
        READ: if (rd_acc) begin
          if (rcol == LAST_COL) begin
            rcol  <= '0;
            rsel  <= rsel + 2'd1;
            state <= IDLE;
          end else begin
            rcol  <= rcol + CB'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pulse once for each released slot.
  always_ff @(posedge clk) begin
    if (!rst_n) line_done <= 1'b0;
    else        line_done <= rd_last;
  end

  // Window taps. Row r reads slot rsel+r and column k reads rcol+k, both
  // wrapping naturally through their pointer widths. Taps are packed MSB first
  // in row-major order.
  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar k = 0; k < 3; k++) begin : g_col
      logic [1:0]    slot;
      logic [CB-1:0] col;
      assign slot = rsel + 2'(r);
      assign col  = rcol + CB'(k);
      assign m_data[(8 - (r * 3 + k)) * DATA_WIDTH +: DATA_WIDTH] = mem[slot][col];
    end
  end

endmodule

// File: tb/tb_conv_window_reader.sv
// Bench for conv_window_reader with W=8, DATA_WIDTH=8. The pixel with global
// index n since reset carries value n, which equals 8*L+c for line L, col c.
// A line-history model predicts every output each cycle. Directed literal
// checks pin the model at the interesting points.
module tb_conv_window_reader;

  localparam int DW = 8;
  localparam int W  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [9*DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          line_done;

  conv_window_reader #(
    .DATA_WIDTH(DW), .IMAGE_WIDTH_SIZE(W), .IMAGE_WIDTH_LOG2_SIZE(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .line_done(line_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: the history of accepted pixels, the number of lines consumed,
  // the current window column, and whether a line is being emitted.
  int pix [0:255];
  int m_wr = 0, m_lines = 0, m_col = 0;
  bit m_open = 0, m_ld = 0;
  int mc0;
  bit mwr, macc, mld;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_wr = 0; m_lines = 0; m_col = 0; m_open = 0; m_ld = 0;
    end else begin
      mc0  = m_wr - W * m_lines;
      mwr  = s_valid && (mc0 < 4 * W);
      macc = m_open && m_ready;
      mld  = 0;
      if (mwr) begin pix[m_wr] = int'(s_data); m_wr++; end
      if (macc) begin
        if (m_col == W - 1) begin m_col = 0; m_lines++; m_open = 0; mld = 1; end
        else m_col++;
      end else if (!m_open && mc0 >= 3 * W) m_open = 1;
      m_ld = mld;
    end
  end

  function automatic logic [71:0] exp_win();
    logic [71:0] v = '0;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++)
        v[(8 - (r * 3 + k)) * 8 +: 8] = 8'(pix[(m_lines + r) * W + (m_col + k) % W]);
    return v;
  endfunction

  int cnt;
  always @(negedge clk) begin
    if (cmp_en) begin
      cnt = m_wr - W * m_lines;
      chk("s_ready", 72'(s_ready), 72'(cnt < 4 * W));
      chk("m_valid", 72'(m_valid), 72'(m_open));
      chk("line_done", 72'(line_done), 72'(m_ld));
      chk("count", 72'(dut.count), 72'(cnt));
      if (m_open) chk("m_data", m_data, exp_win());
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 0; s_valid = 0; m_ready = 0; s_data = '0;
    step();
    rst_n = 1;
  endtask

  // Write pixels with indices [first, first+n), one per cycle.
  task automatic write_px(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      s_valid = 1; s_data = 8'(first + i);
      step();
    end
    s_valid = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  logic [71:0] win0, winw, win1;

  initial begin
    win0 = {8'd0, 8'd1, 8'd2, 8'd8, 8'd9, 8'd10, 8'd16, 8'd17, 8'd18};
    winw = {8'd7, 8'd0, 8'd1, 8'd15, 8'd8, 8'd9, 8'd23, 8'd16, 8'd17};
    win1 = {8'd8, 8'd9, 8'd10, 8'd16, 8'd17, 8'd18, 8'd24, 8'd25, 8'd26};
    rst_n = 0; s_valid = 0; m_ready = 0; s_data = '0;
    idle(2);
    rst_n = 1;
    cmp_en = 1;
    chk("rst m_valid", 72'(m_valid), 72'd0);
    chk("rst s_ready", 72'(s_ready), 72'd1);
    chk("rst line_done", 72'(line_done), 72'd0);
    chk("rst count", 72'(dut.count), 72'd0);

    // Fill: 23 pixels, then the 24th; the window opens one cycle later.
    write_px(0, 23);
    chk("fill23 count", 72'(dut.count), 72'd23);
    chk("fill23 m_valid", 72'(m_valid), 72'd0);
    write_px(23, 1);
    chk("fill24 count", 72'(dut.count), 72'd24);
    chk("fill24 m_valid", 72'(m_valid), 72'd0);
    step();
    chk("open m_valid", 72'(m_valid), 72'd1);
    chk("first window", m_data, win0);

    // Streaming: 7 accepts reach column 7, the 8th closes the line.
    m_ready = 1;
    idle(7);
    chk("wrap window", m_data, winw);
    step();
    chk("done pulse", 72'(line_done), 72'd1);
    chk("done m_valid", 72'(m_valid), 72'd0);
    chk("done count", 72'(dut.count), 72'd16);
    idle(3);
    chk("idle m_valid", 72'(m_valid), 72'd0);
    chk("idle line_done", 72'(line_done), 72'd0);
    m_ready = 0;
    write_px(24, 8);
    chk("refill m_valid", 72'(m_valid), 72'd0);
    step();
    chk("line1 m_valid", 72'(m_valid), 72'd1);
    chk("line1 window", m_data, win1);

    // Backpressure: a full set of 32 pixels, then a dropped pixel.
    do_reset();
    write_px(0, 32);
    chk("full s_ready", 72'(s_ready), 72'd0);
    s_valid = 1; s_data = 8'd99;
    step();
    s_valid = 0;
    chk("drop count", 72'(dut.count), 72'd32);
    m_ready = 1;
    idle(8);
    m_ready = 0;
    chk("release s_ready", 72'(s_ready), 72'd1);
    chk("release line_done", 72'(line_done), 72'd1);
    chk("next wsel", 72'(dut.wsel), 72'd0);
    chk("next wcol", 72'(dut.wcol), 72'd0);
    write_px(32, 1);
    chk("slot0 col0", 72'(dut.mem[0][0]), 72'd32);
    step();
    chk("bp2 m_valid", 72'(m_valid), 72'd1);
    chk("bp2 top row", 72'(m_data[71:48]), 72'({8'd8, 8'd9, 8'd10}));
    chk("bp2 bot row", 72'(m_data[23:0]), 72'({8'd24, 8'd25, 8'd26}));

    // Simultaneous write and final accept at count 31.
    do_reset();
    write_px(0, 31);
    m_ready = 1;
    idle(7);
    chk("sim rcol", 72'(dut.rcol), 72'd7);
    chk("sim count31", 72'(dut.count), 72'd31);
    s_valid = 1; s_data = 8'd31;
    step();
    s_valid = 0; m_ready = 0;
    chk("sim count", 72'(dut.count), 72'd24);
    chk("sim wsel", 72'(dut.wsel), 72'd0);
    chk("sim rsel", 72'(dut.rsel), 72'd1);
    step();
    m_ready = 1;
    idle(3);
    m_ready = 0;
    chk("mid rcol", 72'(dut.rcol), 72'd3);

    // Reset in the middle of a line.
    rst_n = 0;
    step();
    rst_n = 1;
    chk("mid m_valid", 72'(m_valid), 72'd0);
    chk("mid count", 72'(dut.count), 72'd0);
    chk("mid s_ready", 72'(s_ready), 72'd1);
    chk("mid line_done", 72'(line_done), 72'd0);
    chk("mid wsel", 72'(dut.wsel), 72'd0);
    chk("mid wcol", 72'(dut.wcol), 72'd0);
    write_px(0, 24);
    step();
    chk("after rst window", m_data, win0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv_window_reader.md
Name: conv_window_reader

Overview:
- Sits between the pixel ingress stream and the 3x3 convolution datapath.
- Stores incoming pixels in four rotating internal line stores, each IMAGE_WIDTH_SIZE pixels wide.
- Once three lines are buffered, reads three adjacent lines in parallel and presents one 3x3 window per accepted cycle.
- Pulses line_done whenever a line slot is released, so the host can supply another line.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- IMAGE_WIDTH_SIZE, 512, pixels per line (W); power of two.
- IMAGE_WIDTH_LOG2_SIZE, 9, log2(W); width of column pointers.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- s_data  in  DATA_WIDTH  incoming pixel, raster order.
- s_valid  in  1  s_data valid this cycle.
- s_ready  out  1  block can accept a pixel this cycle.
- m_data  out  9*DATA_WIDTH  3x3 window.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accepts window this cycle.
- line_done  out  1  one-cycle pulse; one line slot freed.

Behaviour:
- Storage: four line stores, slot index 0..3. Contents are not cleared by reset.
- Write side:
  - A write occurs when s_valid && s_ready. It stores line[wsel][wcol] <= s_data, then wcol increments.
  - When wcol == W-1, wcol wraps to 0 and wsel increments mod 4.
  - s_valid while s_ready=0: pixel dropped; no pointer or count change.
- Fill count (IMAGE_WIDTH_LOG2_SIZE+3 bits, range 0..4W):
  - +1 per write.
  - -W on line completion.
  - Both in the same cycle: count + 1 - W.
- s_ready = (count < 4W). This is combinational from the registered count.
- Read FSM has two states, IDLE and READ:
  - IDLE -> READ when count >= 3W, evaluated on the registered count, so m_valid rises one cycle after count reaches 3W.
  - In READ, m_valid = 1. In IDLE, m_valid = 0.
  - An accept is m_valid && m_ready. On each accept, rcol increments.
  - An accept with rcol == W-1 is a line completion: rcol <= 0, rsel <= rsel+1 mod 4, count -= W, state <= IDLE.
  - m_valid is therefore low for at least one cycle between lines. The next line starts on the cycle after count >= 3W is seen in IDLE.
- Window contents:
  - Rows are top = slot rsel, mid = slot rsel+1, bot = slot rsel+2 (slot arithmetic mod 4).
  - Columns are c0 = rcol, c1 = rcol+1, c2 = rcol+2, all mod W, so wrap-around windows are emitted.
  - Packing, MSB first: top[c0], top[c1], top[c2], mid[c0], mid[c1], mid[c2], bot[c0], bot[c1], bot[c2].
  - Reads are combinational from the stores and pointers, so m_data is stable while m_valid=1 and m_ready=0.
  - W windows are emitted per line.
- line_done is registered: high for exactly the one cycle following a line-completion accept.
- No corruption: the free slot is always rsel+3. The -W release happens only after the top line is fully consumed, so writes never overwrite a slot being read.
- Reset values: wcol=0, wsel=0, rcol=0, rsel=0, count=0, state=IDLE, m_valid=0, line_done=0, s_ready=1.
- Reset mid-operation: all of the above restored on the next edge, and any partial line is discarded.
- m_data is don't-care while m_valid=0.

Test Plan:
All scenarios use W=8 and DATA_WIDTH=8, and drive pixel value = 8*L+c for line L, column c.
- Fill: reset, then write 23 pixels -> m_valid=0, count=23. Write the 24th pixel -> count=24, and m_valid=1 on the following cycle.
- Window values:
  - First window = {0,1,2,8,9,10,16,17,18}.
  - Window at rcol=7 = {7,0,1,15,8,9,23,16,17} (column wrap).
- Streaming: with m_ready held 1, exactly 8 consecutive accepts occur.
  - line_done is high for one cycle after the 8th accept, and m_valid=0 in that cycle.
  - count=16, and the FSM stays in IDLE until 8 more pixels arrive.
- Backpressure: m_ready=0 while 32 pixels are written -> s_ready=0 at count=32, and a 33rd pixel (value 99) is dropped.
  - After 8 accepts, s_ready=1 again.
  - The next pixel lands in slot 0, col 0. The second line's windows show top row 8,9,10 and bot row 24,25,26.
- Simultaneous events: count=31 in READ at rcol=7, with a write and an accept in the same cycle -> count=24, wsel advances to slot 0, rsel=1.
- Reset mid-read: assert rst_n=0 for one cycle during READ at rcol=3 -> next cycle m_valid=0, count=0, s_ready=1, line_done=0.
  - The refill then restarts at slot 0, col 0.
